// File: rtl/eth_pkg.sv
// Constants and helpers shared by the Ethernet receive and transmit paths:
// framing bytes, CRC-32 parameters and the receive framer state encoding.
package eth_pkg;

   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;
   localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
   localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
   localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

   typedef enum logic [1:0] {
      ST_DROP     = 2'd0,
      ST_IDLE     = 2'd1,
      ST_PREAMBLE = 2'd2,
      ST_DATA     = 2'd3
   } rx_state_t;

   // Reflected CRC-32 advanced by one byte, LSB first, no final inversion.
   function automatic logic [31:0] crc32_step8(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] c;
      c = crc ^ {24'h000000, data};
      for (int i = 0; i < 8; i++) begin
         if (c[0]) begin
            c = (c >> 1) ^ CRC_POLY;
         end else begin
            c = c >> 1;
         end
      end
      return c;
   endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational next-CRC for one input byte; shared with the transmit FCS generator.
module crc32_d8
   import eth_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [7:0]  data,
   output logic [31:0] crc_out
);

   // Single byte step of the reflected CRC-32.
   always_comb begin
      crc_out = crc32_step8(crc_in, data);
   end

endmodule

// File: rtl/gmii_rx_mac.sv
// GMII receive framer: strips preamble/SFD, holds back the FCS through a
// 5-byte delay line and flags CRC, length and GMII errors on the last beat.
module gmii_rx_mac
   import eth_pkg::*;
#(
   parameter int MIN_FRAME = 64,
   parameter int MAX_FRAME = 1518
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       gmii_rx_dv,
   input  logic       gmii_rx_er,
   input  logic [7:0] gmii_rxd,
   output logic [7:0] m_data,
   output logic       m_valid,
   output logic       m_last,
   output logic       m_error,
   output logic       stat_frame_ok,
   output logic       stat_frame_err
);

   localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME);
   localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME);

   rx_state_t       state_r;
   rx_state_t       state_nxt_s;
   logic [31:0]     crc_r;
   logic [31:0]     crc_nxt_s;
   logic [15:0]     cnt_r;
   logic            err_r;
   logic [4:0][7:0] dl_r;
   logic [2:0]      dl_cnt_r;

   logic       sfd_s;
   logic       push_s;
   logic       eof_s;
   logic       full_s;
   logic       frame_bad_s;
   logic [7:0] data_s;
   logic       valid_s;
   logic       last_s;
   logic       error_s;
   logic       ok_s;
   logic       bad_s;

   crc32_d8 u_crc (
      .crc_in  (crc_r),
      .data    (gmii_rxd),
      .crc_out (crc_nxt_s)
   );

   assign sfd_s       = (state_r == ST_PREAMBLE) && gmii_rx_dv && (gmii_rxd == SFD_BYTE);
   assign push_s      = (state_r == ST_DATA) && gmii_rx_dv;
   assign eof_s       = (state_r == ST_DATA) && !gmii_rx_dv;
   assign full_s      = (dl_cnt_r == 3'd5);
   assign frame_bad_s = err_r || (crc_r != CRC_RESIDUE) || (cnt_r < MIN_LEN) || (cnt_r > MAX_LEN);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_DROP;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; DROP waits for a gap so we never lock onto mid-frame bytes.
   always_comb begin
      state_nxt_s = ST_DROP;
      case (state_r)
         ST_DROP:     state_nxt_s = gmii_rx_dv ? ST_DROP : ST_IDLE;
         ST_IDLE: begin
            if (!gmii_rx_dv) begin
               state_nxt_s = ST_IDLE;
            end else if (gmii_rxd == PREAMBLE_BYTE) begin
               state_nxt_s = ST_PREAMBLE;
            end else begin
               state_nxt_s = ST_DROP;
            end
         end
         ST_PREAMBLE: begin
            if (!gmii_rx_dv) begin
               state_nxt_s = ST_IDLE;
            end else if (gmii_rxd == PREAMBLE_BYTE) begin
               state_nxt_s = ST_PREAMBLE;
            end else if (gmii_rxd == SFD_BYTE) begin
               state_nxt_s = ST_DATA;
            end else begin
               state_nxt_s = ST_DROP;
            end
         end
         ST_DATA:     state_nxt_s = gmii_rx_dv ? ST_DATA : ST_IDLE;
         default:     state_nxt_s = ST_DROP;
      endcase
   end

   // Output decode; a runt (delay line not yet full) emits nothing but still counts as bad.
   always_comb begin
      data_s  = dl_r[4];
      valid_s = 1'b0;
      last_s  = 1'b0;
      error_s = 1'b0;
      ok_s    = 1'b0;
      bad_s   = 1'b0;
      if (push_s && full_s) begin
         valid_s = 1'b1;
      end else if (eof_s && full_s) begin
         valid_s = 1'b1;
         last_s  = 1'b1;
         error_s = frame_bad_s;
         ok_s    = !frame_bad_s;
         bad_s   = frame_bad_s;
      end else if (eof_s) begin
         bad_s   = 1'b1;
      end else begin
         valid_s = 1'b0;
      end
   end

   // Delay line, CRC, byte counter and sticky error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         crc_r    <= CRC_INIT;
         cnt_r    <= 16'd0;
         err_r    <= 1'b0;
         dl_r     <= '0;
         dl_cnt_r <= 3'd0;
      end else if (sfd_s) begin
         crc_r    <= CRC_INIT;
         cnt_r    <= 16'd0;
         err_r    <= 1'b0;
         dl_cnt_r <= 3'd0;
      end else if (push_s) begin
         crc_r    <= crc_nxt_s;
         cnt_r    <= (cnt_r == 16'hFFFF) ? cnt_r : cnt_r + 16'd1;
         err_r    <= err_r | gmii_rx_er;
         dl_r     <= {dl_r[3:0], gmii_rxd};
         dl_cnt_r <= full_s ? 3'd5 : dl_cnt_r + 3'd1;
      end else if (eof_s) begin
         dl_cnt_r <= 3'd0;
      end else begin
         dl_cnt_r <= dl_cnt_r;
      end
   end

   // Registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_data         <= 8'd0;
         m_valid        <= 1'b0;
         m_last         <= 1'b0;
         m_error        <= 1'b0;
         stat_frame_ok  <= 1'b0;
         stat_frame_err <= 1'b0;
      end else begin
         m_data         <= valid_s ? data_s : 8'd0;
         m_valid        <= valid_s;
         m_last         <= last_s;
         m_error        <= error_s;
         stat_frame_ok  <= ok_s;
         stat_frame_err <= bad_s;
      end
   end

endmodule
